// File: rtl/prefix_adder_6b.sv
// 6-bit unsigned Kogge-Stone adder with a registered 7-bit result {ov, s5..s0}.
// Optional macro PREFIX_ADDER_IN_REG_EN adds an input register stage (latency 2).
// Otherwise the latency is 1 cycle.
// Scalar port names are part of the block's external interface and are kept as-is.

module prefix_adder_6b (
  input  logic clk,
  input  logic rst_n,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic y4,
  input  logic y5,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic ov
);

  logic [5:0] x_op;
  logic [5:0] y_op;

`ifdef PREFIX_ADDER_IN_REG_EN
  logic [5:0] x_q, x_d;
  logic [5:0] y_q, y_d;

  always_comb begin
    x_d = {x5, x4, x3, x2, x1, x0};
    y_d = {y5, y4, y3, y2, y1, y0};
  end

  // Input stage: operands captured one cycle ahead of the prefix tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_op = x_q;
  assign y_op = y_q;
`else
  assign x_op = {x5, x4, x3, x2, x1, x0};
  assign y_op = {y5, y4, y3, y2, y1, y0};
`endif

  // Bitwise generate/propagate.
  logic [5:0] g0, p0;
  // Group generate after each level. Bit i is final (i down to 0) once i < 2^level.
  logic [5:0] g1, g2, g3;
  // Group propagate is only kept where a later black cell still needs it.
  logic [5:2] p1;
  logic [5:4] p2;

  for (genvar i = 0; i < 6; i++) begin : g_gp_cell
    assign g0[i] = x_op[i] & y_op[i];
    assign p0[i] = x_op[i] ^ y_op[i];
  end

  // Level 1, span 1.
  assign g1[0] = g0[0];
  assign g1[1] = g0[1] | (p0[1] & g0[0]);
  for (genvar i = 2; i < 6; i++) begin : g_l1_black
    assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
    assign p1[i] = p0[i] & p0[i-1];
  end

  // Level 2, span 2.
  assign g2[1:0] = g1[1:0];
  for (genvar i = 2; i < 4; i++) begin : g_l2_grey
    assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
  end
  for (genvar i = 4; i < 6; i++) begin : g_l2_black
    assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
    assign p2[i] = p1[i] & p1[i-2];
  end

  // Level 3, span 4.
  assign g3[3:0] = g2[3:0];
  for (genvar i = 4; i < 6; i++) begin : g_l3_grey
    assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
  end

  logic [6:0] sum_d, sum_q;

  // Post-processing: sum bit i uses the carry out of bits i-1..0.
  always_comb begin
    sum_d    = '0;
    sum_d[0] = p0[0];
    for (int i = 1; i < 6; i++) begin
      sum_d[i] = p0[i] ^ g3[i-1];
    end
    sum_d[6] = g3[5];
  end

  // Output stage: all 7 result bits are captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign s0 = sum_q[0];
  assign s1 = sum_q[1];
  assign s2 = sum_q[2];
  assign s3 = sum_q[3];
  assign s4 = sum_q[4];
  assign s5 = sum_q[5];
  assign ov = sum_q[6];

endmodule

// File: tb/tb_prefix_adder_6b.sv
// Self-checking bench for prefix_adder_6b using a latency-aware scoreboard queue.
module tb_prefix_adder_6b;

`ifdef PREFIX_ADDER_IN_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] xv;
  logic [5:0] yv;
  logic       s0, s1, s2, s3, s4, s5, ov;
  logic [6:0] res;

  int tests;
  int fails;
  logic [6:0] sb_q[$];

  assign res = {ov, s5, s4, s3, s2, s1, s0};

  prefix_adder_6b dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x0   (xv[0]),
    .x1   (xv[1]),
    .x2   (xv[2]),
    .x3   (xv[3]),
    .x4   (xv[4]),
    .x5   (xv[5]),
    .y0   (yv[0]),
    .y1   (yv[1]),
    .y2   (yv[2]),
    .y3   (yv[3]),
    .y4   (yv[4]),
    .y5   (yv[5]),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3),
    .s4   (s4),
    .s5   (s5),
    .ov   (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one operand pair, push its expected sum, then pop and compare whatever is due.
  task automatic drive(input string tag, input logic [5:0] a, input logic [5:0] b,
                       input logic [6:0] exp);
    logic [6:0] e;
    @(negedge clk);
    xv = a;
    yv = b;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() >= Lat) begin
      e = sb_q.pop_front();
      check(tag, res, e);
    end
  endtask

  task automatic add(input string tag, input int a, input int b);
    logic [6:0] e;
    e = 7'(a + b);
    drive(tag, 6'(a), 6'(b), e);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    xv    = 6'd63;
    yv    = 6'd63;

    // Outputs held at zero while reset is low, even with the clock running.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", res, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    repeat (Lat) add("reset_release", 63, 63);
    check("reset_release_126", res, 7'd126);

    // Corner sums.
    add("zero", 0, 0);
    add("one_plus_63", 1, 63);
    add("max_plus_max", 63, 63);
    add("alt_21_42", 21, 42);
    repeat (Lat - 1) add("flush", 0, 0);

    // Back-to-back pipelining.
    add("b2b_64", 32, 32);
    add("b2b_8", 5, 3);
    repeat (Lat - 1) add("flush", 0, 0);

    // Async reset mid-stream while the output holds 64.
    repeat (Lat) add("pre_reset_64", 32, 32);
    check("holds_64", res, 7'd64);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", res, 7'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Carry chain: 63 + y gives ov only for y >= 1 and s = y - 1.
    for (int y = 0; y < 64; y++) begin
      logic [6:0] e;
      e = (y == 0) ? 7'd63 : {1'b1, 6'(y - 1)};
      drive("carry_chain", 6'd63, 6'(y), e);
    end

    // Exhaustive sweep.
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        add("exhaustive", a, b);
      end
    end
    repeat (Lat - 1) add("flush", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prefix_adder_6b.md
Name: prefix_adder_6b

Overview:
- 6-bit unsigned parallel-prefix (Kogge-Stone) adder with a registered 7-bit result: sum bits s0..s5 plus carry-out ov.
- Pure datapath leaf block. Operands and results are exposed as individual scalar bit ports, bit 0 = LSB.
- Used wherever a fast small-width add with a clean registered output is needed.

Parameters:
- None. Width is fixed at 6 bits.

Ports:
- clk  input  1  system clock, all state rising-edge triggered
- rst_n  input  1  asynchronous active-low reset
- x0..x5  input  1 each  operand X, x0 = LSB, x5 = MSB
- y0..y5  input  1 each  operand Y, y0 = LSB, y5 = MSB
- s0..s5  output  1 each  registered sum bits, s0 = LSB
- ov  output  1  registered carry-out (sum bit 6)

Behaviour:
- Arithmetic: {ov,s5,s4,s3,s2,s1,s0} = X + Y, unsigned. The result is 7 bits, so no information is lost.
  - Range is 0..126.
  - No carry-in.
  - ov=1 exactly when X+Y >= 64.
- Pre-processing, per bit i: g_i = x_i & y_i, p_i = x_i ^ y_i.
- Prefix tree, Kogge-Stone, 3 levels, spans 1/2/4.
  - Combine operator: (G,P)o(G',P') = (G | P&G', P&P').
  - Level 1 combines i with i-1; level 2 with i-2; level 3 with i-4.
  - Where the neighbour index would be < 0, pass through unchanged.
- Post-processing:
  - s0 = p0.
  - s_i = p_i ^ G[i-1:0] for i = 1..5.
  - ov = G[5:0].
- Tree is built structurally from g/p cells and black/grey prefix cells. A behavioural "+" is not permitted in the core.
- Output register: all 7 result bits are captured together on the rising clk edge.
  - Latency is 1 cycle: operands stable before edge N appear on the outputs after edge N.
  - New operands are accepted every cycle (throughput 1/cycle). No handshake.
- Reset:
  - rst_n low immediately forces s0..s5=0 and ov=0, independent of clk.
  - While rst_n is low, the outputs stay 0.
  - The first capture is on the first rising clk edge after rst_n deasserts.
  - Reset asserted mid-stream discards any in-flight result.
- Boundaries:
  - 0+0 -> 0.
  - 63+63 -> 126 (ov=1, s=62).
  - 1+63 -> 64 (ov=1, s=0); the carry ripples through all 6 prefix positions.
  - X or Z on inputs is not handled specially.

Optional Feature:
- Macro: PREFIX_ADDER_IN_REG_EN.
- Defined:
  - x0..x5 and y0..y5 are additionally registered (async active-low reset to 0) before the prefix tree.
  - Total latency becomes 2 cycles; throughput stays 1/cycle.
  - Reset clears both the input and output stages.
- Undefined: no input registers; latency 1 cycle as described above.

Test Plan:
- Reset: hold rst_n=0 with X=63, Y=63 and clk toggling -> ov=0, s=0 throughout. Release rst_n -> after the next edge, ov=1, s=62.
- Corner sums:
  - X=0, Y=0 -> 0.
  - X=1, Y=63 -> ov=1, s=0.
  - X=63, Y=63 -> ov=1, s=62.
  - X=21, Y=42 -> ov=0, s=63.
- Exhaustive: all 4096 pairs, one per cycle, compared against X+Y delayed by the configured latency (1, or 2 with PREFIX_ADDER_IN_REG_EN) -> error count 0.
- Back-to-back pipelining: apply X=32,Y=32 then X=5,Y=3 on consecutive cycles -> outputs 64 (ov=1, s=0) then 8 on consecutive cycles.
- Async reset mid-stream: drive rst_n low between edges while the output holds 64 -> outputs go to 0 before the next clk edge.
- Carry-chain propagation: X=63 with Y stepping 0..63 -> ov=0 only for Y=0, and s = Y-1 for Y>=1.
